// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {rem,q} left, trial-subtract the divisor.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] q_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // Remainder stays below the divisor, so the W+1-bit trial never wraps; trial[W] is its sign.
    always_comb begin
        shifted = {rem_i, q_i[W-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[W]) begin
            rem_o = shifted[W-1:0];
            q_o   = {q_i[W-2:0], 1'b0};
        end else begin
            rem_o = trial[W-1:0];
            q_o   = {q_i[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_32bit_iter.sv
// Iterative signed divider: magnitudes latched at start, WIDTH restoring steps, then sign fix-up.
// state | meaning
// IDLE  | waiting for start
// CALC  | one quotient bit per cycle, WIDTH cycles
// FIX   | apply quotient sign and exception masking
// DONE  | result_ready pulse; start here chains the next operation
module div_32bit_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_ready,
    output logic             busy
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             sign_q;
    logic             zero_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             ready_q;
    logic             busy_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quo_signed;
    logic             last_step;

    // |INT_MIN| wraps back to INT_MIN, which read as unsigned is exactly 2^(WIDTH-1).
    assign abs_a      = A[WIDTH-1] ? -A : A;
    assign abs_b      = B[WIDTH-1] ? -B : B;
    assign quo_signed = sign_q ? -quo_q : quo_q;
    assign last_step  = (cnt_q == CNT_W'(WIDTH - 1));

    div_step #(
        .W(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .q_i      (quo_q),
        .divisor_i(dvsr_q),
        .rem_o    (rem_d),
        .q_o      (quo_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            // A start in any state relaunches; an aborted operation never reaches FIX.
            if (start) begin
                state_q <= CALC;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                rem_q   <= '0;
                quo_q   <= abs_a;
                dvsr_q  <= abs_b;
                sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                zero_q  <= (B == '0);
                ovf_q   <= (A == INT_MIN[WIDTH-1:0]) && (B == NEG_ONE[WIDTH-1:0]);
            end else begin
                case (state_q)
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_step) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        if (zero_q || ovf_q) begin
                            result_q <= '0;
                            exc_q    <= 1'b1;
                        end else begin
                            result_q <= quo_signed;
                            exc_q    <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign result       = result_q;
    assign exception    = exc_q;
    assign result_ready = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_div_32bit_iter.sv
// Bench for div_32bit_iter: vector table plus restart/reset/back-to-back sequences, scoreboard-checked.
module tb_div_32bit_iter;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } sb_t;

    localparam int LAT = 34;
    localparam int NVEC = 14;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        exception;
    logic        result_ready;
    logic        busy;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pend_start = 0;
    int   pend_due = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;
    sb_t  sb[$];
    vec_t vecs[NVEC];

    div_32bit_iter dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .result      (result),
        .exception   (exception),
        .result_ready(result_ready),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: runs 1 time unit after each rising edge.
    always @(posedge clock) begin
        sb_t e;
        logic exp_busy;
        cyc = cyc + 1;
        #1;
        if (sb.size() > 0 && cyc > sb[0].due) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: no result_ready seen, expected at cycle %0d (now %0d)", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (result_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_ready: result_ready=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(e.due));
                chk("result", result, e.res);
                chk("exception", {31'b0, exception}, {31'b0, e.exc});
                last_res = e.res;
                last_exc = e.exc;
            end
        end else if (result_ready !== 1'b0) begin
            chk("ready_known", {31'b0, result_ready}, 32'd0);
        end
        exp_busy = (sb.size() > 0) && (cyc > pend_start) && (cyc < pend_due);
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("result_hold", result, last_res);
        chk("exception_hold", {31'b0, exception}, {31'b0, last_exc});
    end

    // Called at a falling edge; returns at the following falling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc);
        sb_t e;
        A = a;
        B = b;
        start = 1'b1;
        if (sb.size() > 0 && pend_due > cyc) void'(sb.pop_back());
        e.res = res;
        e.exc = exc;
        e.due = cyc + LAT;
        sb.push_back(e);
        pend_start = cyc;
        pend_due = cyc + LAT;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 1000 && cyc < t; i++) @(negedge clock);
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = 32'($signed(a) / $signed(b));
            exc = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rres;
        logic        rexc;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
        vecs[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0};
        vecs[3]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
        vecs[4]  = '{32'hFFFF_FFF9,  32'd100,        32'd0,          1'b0};
        vecs[5]  = '{32'd5,          32'd0,          32'd0,          1'b1};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
        vecs[8]  = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};
        vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0};
        vecs[10] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[11] = '{32'hFFFF_FFFF,  32'd2,          32'd0,          1'b0};
        vecs[12] = '{32'd0,          32'd5,          32'd0,          1'b0};
        vecs[13] = '{32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'd0,          1'b0};

        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", result, 32'd0);
        chk("reset_exception", {31'b0, exception}, 32'd0);
        chk("reset_ready", {31'b0, result_ready}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
            wait_idle();
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 1) rb = -rb;
            model(ra, rb, rres, rexc);
            issue(ra, rb, rres, rexc);
            wait_idle();
        end

        // Restart mid-calculation: only the second operation reports.
        c0 = cyc;
        issue(32'd1000, 32'd10, 32'd100, 1'b0);
        wait_until(c0 + 10);
        issue(32'd9, 32'd3, 32'd3, 1'b0);
        wait_idle();

        // Reset mid-operation: no ready pulse, outputs cleared, then a clean run.
        c0 = cyc;
        issue(32'd100, 32'd7, 32'd14, 1'b0);
        wait_until(c0 + 20);
        reset = 1'b1;
        sb.delete();
        last_res = '0;
        last_exc = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wait_until(c0 + 60);
        issue(32'd100, 32'd7, 32'd14, 1'b0);
        wait_idle();

        // Back-to-back: new start lands in the DONE cycle of the first.
        c0 = cyc;
        issue(32'd100, 32'd7, 32'd14, 1'b0);
        wait_until(c0 + LAT);
        issue(32'd7, 32'd7, 32'd1, 1'b0);
        wait_idle();

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div_32bit_iter.md
Name: div_32bit_iter

Overview:
- Iterative signed 32-bit integer divider (restoring, one quotient bit per cycle) for the multdiv path next to the ALU.
- Computes a truncated quotient A/B in two's complement.
- A single-cycle start pulse launches an operation; a single-cycle ready pulse delivers the result and exception flag.
- Fixed latency, so the pipeline stall logic can count cycles or wait on the ready pulse.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; samples A and B on this edge.
- A  input  WIDTH  dividend, signed.
- B  input  WIDTH  divisor, signed.
- result  output  WIDTH  quotient, signed, truncated toward zero.
- exception  output  1  divide-by-zero or overflow flag.
- result_ready  output  1  one-cycle pulse when result/exception are valid.
- busy  output  1  high from the cycle after start until result_ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values: result=0, exception=0, result_ready=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE: waits for start.
  - CALC: WIDTH cycles.
  - FIX: 1 cycle.
  - DONE: 1 cycle, result_ready=1.
- Transitions: IDLE -start-> CALC -> FIX -> DONE -> IDLE. DONE also goes directly to CALC if start is high in DONE.
- On the start edge, register the following:
  - sign_q = A[W-1]^B[W-1].
  - |A| into the quotient/dividend register.
  - |B| into the divisor register.
  - Remainder register cleared.
  - Zero/overflow checks: zero = (B==0); ovf = (A==0x80000000 && B==0xFFFFFFFF).
- CALC step, each cycle:
  - {rem,q} shifted left 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial and q[0]=1; else q[0]=0.
  - Counter increments; leave CALC after WIDTH steps.
- |0x80000000| is treated as an unsigned magnitude 2^31. The datapath is WIDTH+1 bits internally, so no overflow occurs inside the step.
- FIX:
  - Quotient negated if sign_q.
  - If zero or ovf: result=0 and exception=1; else exception=0.
  - result and exception are updated here.
- Latency: start sampled at edge N; result_ready high during cycle N+WIDTH+2 (34 for WIDTH=32). Latency is identical for all operand values, including the exception cases.
- result and exception hold their value after the ready pulse until the next FIX. They are not cleared at the next start.
- start while busy (CALC/FIX): the in-flight operation is aborted. New operands are latched, the counter restarts, and no ready pulse is issued for the aborted operation.
- start during DONE: the ready pulse still occurs that cycle, and the new operation begins.
- Reset mid-operation: immediate return to IDLE with reset values on the next edge. No ready pulse.
- Remainder is internal only and is not exported.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, FIX, DONE}.
  - INT_MIN constant 0x80000000.
  - NEG_ONE constant 0xFFFFFFFF.
  - Default WIDTH and CNT_W.
- Sub-module div_step: purely combinational single restoring step. Inputs rem, q, divisor; outputs next rem and next q. Instantiated once and fed by the state registers.

Test Plan:
- A=100, B=7, start pulse at cycle 0 -> result_ready only at cycle 34; result=14; exception=0; busy high for cycles 1-33.
- Sign quadrants:
  - -100/7 -> 0xFFFFFFF2 (-14).
  - 100/-7 -> 0xFFFFFFF2.
  - -100/-7 -> 14.
  - -7/100 -> 0.
  - All with exception=0.
- Exceptions:
  - A=5, B=0 -> result=0, exception=1, ready at cycle 34.
  - A=0x80000000, B=0xFFFFFFFF -> result=0, exception=1.
  - A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Restart: start with 1000/10 at cycle 0, then start with 9/3 at cycle 10 -> exactly one ready pulse at cycle 44; result=3.
- Reset at cycle 20 of a 100/7 operation -> all outputs 0 from the next edge; no ready pulse through cycle 60. A subsequent 100/7 completes normally at +34.
- Back-to-back: start at cycle 34 (DONE) with 7/7 -> first ready at 34 gives 14; second ready at 68 gives 1. Result holds 14 during cycles 35-67.
